fifo_multicanal: RTL and testbench
==================================

FIFO_MULTICANAL -- requirements
Module: fifo_multicanal

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 8, entries per channel (power of two, 2..256).
REQ-003 SHALL have parameter CHANNELS, default 4, number of independent FIFO channels (1..16).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port push_i, input, CHANNELS, per-channel write strobe, sampled at the clk rising edge.
REQ-008 SHALL have port pop_i, input, CHANNELS, per-channel read strobe, sampled at the clk rising edge.
REQ-009 SHALL have port dato_i, input, CHANNELS*WIDTH, write data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 SHALL have port dato_o, output, CHANNELS*WIDTH, head-of-queue data per channel, packed the same way.
REQ-011 SHALL have port pndng_o, output, CHANNELS, channel holds at least one entry.
REQ-012 SHALL have port full_o, output, CHANNELS, channel holds DEPTH entries.
REQ-013 SHALL have port count_o, output, CHANNELS*($clog2(DEPTH)+1), per-channel occupancy.
REQ-014 SHALL have port overflow_o, output, CHANNELS, sticky flag for a push while full.
REQ-015 SHALL have port underflow_o, output, CHANNELS, sticky flag for a pop while empty.
REQ-016 SHALL have port clr_flags_i, input, CHANNELS, synchronous clear of that channel's sticky flags.

Function
REQ-017 SHALL operate channels fully independently; no event on one channel affects another.
REQ-018 SHALL be first-word-fall-through: dato_o shows the oldest entry combinationally from the registers, and shows 0 when the channel is empty.
REQ-019 SHALL make a push visible on dato_o, pndng_o and count_o one cycle after the push edge (1-cycle write latency).
REQ-020 SHALL make a pop advance dato_o to the next entry and decrement count_o on the same edge.
REQ-021 SHALL track occupancy with wrapping read/write pointers of $clog2(DEPTH) bits plus a count register; pointers wrap from DEPTH-1 to 0.
REQ-022 SHALL, on push and pop in the same cycle with the channel neither empty nor full, write and read, leaving count unchanged.
REQ-023 SHALL, on push and pop in the same cycle while full, perform both operations; count stays DEPTH and no overflow is flagged.
REQ-024 SHALL, on push and pop in the same cycle while empty, accept the push, ignore the pop, and set underflow_o.
REQ-025 SHALL, on pop while empty, leave state unchanged and set underflow_o.
REQ-026 SHALL, on push while full without pop, set overflow_o; data handling is set by REQ-031/REQ-032.
REQ-027 SHALL, when clr_flags_i[c] coincides with a new overflow/underflow event, leave the flag set (set wins).

Reset
REQ-028 SHALL, on rst_n low at any time, immediately clear all pointers and counts, overflow_o and underflow_o to 0, pndng_o and full_o to 0, and drive dato_o to 0.
REQ-029 SHALL discard in-flight contents on mid-operation reset; the first push after rst_n rises is the head entry.
REQ-030 SHALL NOT require storage RAM to be reset; only control state is reset.

Configuration
REQ-031 SHALL, with macro FIFO_OVERWRITE_EN defined, have a push while full (no pop) overwrite the oldest entry: read pointer advances, count stays DEPTH, overflow_o set.
REQ-032 SHALL, without FIFO_OVERWRITE_EN, drop a push while full: contents and pointers unchanged, overflow_o set.

Structure
REQ-033 SHALL place the default WIDTH/DEPTH/CHANNELS constants and a channel status struct typedef (pndng, full, overflow, underflow) in package fifo_pkg.
REQ-034 SHALL implement one channel as sub-module fifo_canal, instantiated CHANNELS times by a generate loop.

Verification
REQ-035 SHALL cover: ch0 push 0x6 then 0xA, then two pops -> dato_o[ch0] shows 0x6, then 0xA, then 0; pndng_o[0] falls after the second pop; other channels stay idle.
REQ-036 SHALL cover: DEPTH=8, push 9 words 0x1..0x9 on ch1 -> full_o[1] after the 8th push, overflow_o[1]=1; head is 0x1 (drop) or 0x2 (FIFO_OVERWRITE_EN).
REQ-037 SHALL cover: pop on empty ch2 -> underflow_o[2]=1 and count_o unchanged; clr_flags_i[2] pulse -> flag 0 next cycle.
REQ-038 SHALL cover: ch3 full, push 0xB plus pop in the same cycle -> count stays 8, overflow_o[3]=0, 0xB read out eighth.
REQ-039 SHALL cover: 20 push/pop cycles on ch0 with pointer wrap, rst_n asserted mid-stream -> outputs zero immediately; post-reset push 0x5 is head.
REQ-040 SHALL cover: all channels pushed simultaneously with distinct data -> each dato_o slice returns only its own channel's data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and the per-channel status record for the multi-channel FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_CHANNELS = 4;

  typedef struct packed {
    logic pndng;
    logic full;
    logic overflow;
    logic underflow;
  } canal_status_t;

endpackage

// File: rtl/fifo_canal.sv
// One first-word-fall-through FIFO channel with sticky overflow/underflow flags.
// Define FIFO_OVERWRITE_EN to make a push while full replace the oldest entry instead of dropping it.
module fifo_canal
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_flags_i,
  input  logic [WIDTH-1:0] dato_i,
  output logic [WIDTH-1:0] dato_o,
  output logic [CW-1:0]    count_o,
  output canal_status_t    status_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             empty, full, wrEn, rdEn, ovfEvent, udfEvent;

  // A pop on an empty channel is ignored; push+pop while full is a plain pass-through.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    ovfEvent = push_i && full && !pop_i;
    udfEvent = pop_i && empty;
    rdEn     = pop_i && !empty;
`ifdef FIFO_OVERWRITE_EN
    wrEn     = push_i;
`else
    wrEn     = push_i && !ovfEvent;
`endif
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;
    count_d  = count_q;
    if (wrEn) wrPtr_d = wrPtr_q + PW'(1);
    if (rdEn || (wrEn && ovfEvent)) rdPtr_d = rdPtr_q + PW'(1);
    if (wrEn && !rdEn && !ovfEvent) count_d = count_q + CW'(1);
    else if (rdEn && !wrEn)         count_d = count_q - CW'(1);
    ovf_d = ovfEvent || (ovf_q && !clr_flags_i);
    udf_d = udfEvent || (udf_q && !clr_flags_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage holds no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wrPtr_q] <= dato_i;
  end

  assign dato_o             = empty ? '0 : mem_q[rdPtr_q];
  assign count_o            = count_q;
  assign status_o.pndng     = !empty;
  assign status_o.full      = full;
  assign status_o.overflow  = ovf_q;
  assign status_o.underflow = udf_q;

endmodule

// File: rtl/fifo_multicanal.sv
// Bank of CHANNELS independent FIFO channels with packed data/count buses.
// Optional overwrite-on-full behaviour is selected with FIFO_OVERWRITE_EN (see fifo_canal).
module fifo_multicanal
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   push_i,
  input  logic [CHANNELS-1:0]   pop_i,
  input  logic [CHANNELS*WIDTH-1:0] dato_i,
  input  logic [CHANNELS-1:0]   clr_flags_i,
  output logic [CHANNELS*WIDTH-1:0] dato_o,
  output logic [CHANNELS-1:0]   pndng_o,
  output logic [CHANNELS-1:0]   full_o,
  output logic [CHANNELS*CW-1:0] count_o,
  output logic [CHANNELS-1:0]   overflow_o,
  output logic [CHANNELS-1:0]   underflow_o
);

  canal_status_t status [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_canal
    fifo_canal #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_canal (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push_i[c]),
      .pop_i      (pop_i[c]),
      .clr_flags_i(clr_flags_i[c]),
      .dato_i     (dato_i[c*WIDTH +: WIDTH]),
      .dato_o     (dato_o[c*WIDTH +: WIDTH]),
      .count_o    (count_o[c*CW +: CW]),
      .status_o   (status[c])
    );

    assign pndng_o[c]     = status[c].pndng;
    assign full_o[c]      = status[c].full;
    assign overflow_o[c]  = status[c].overflow;
    assign underflow_o[c] = status[c].underflow;
  end

endmodule

// File: tb/tb_fifo_multicanal.sv
// Directed self-checking bench for fifo_multicanal at default parameters (16-bit, depth 8, 4 channels).
module tb_fifo_multicanal;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    push_i, pop_i, clr_flags_i;
  logic [N*W-1:0]  dato_i, dato_o;
  logic [N-1:0]    pndng_o, full_o, overflow_o, underflow_o;
  logic [N*CW-1:0] count_o;

  int checks;
  int failures;

  fifo_multicanal #(.WIDTH(W), .DEPTH(D), .CHANNELS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_i),
    .pop_i      (pop_i),
    .dato_i     (dato_i),
    .clr_flags_i(clr_flags_i),
    .dato_o     (dato_o),
    .pndng_o    (pndng_o),
    .full_o     (full_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] headOf(input int c);
    return dato_o[c*W +: W];
  endfunction

  function automatic logic [CW-1:0] countOf(input int c);
    return count_o[c*CW +: CW];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change #1 after a rising edge; one edge is applied, then strobes drop.
  task automatic applyStimulus(input logic [N-1:0] push, input logic [N-1:0] pop,
                               input logic [N-1:0] clr, input logic [N*W-1:0] data);
    push_i      = push;
    pop_i       = pop;
    clr_flags_i = clr;
    dato_i      = data;
    @(posedge clk);
    #1;
    push_i      = '0;
    pop_i       = '0;
    clr_flags_i = '0;
    dato_i      = '0;
  endtask

  function automatic logic [N*W-1:0] onChannel(input int c, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[c*W +: W] = v;
    return r;
  endfunction

  logic [W-1:0] firstHead;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    push_i = '0;
    pop_i = '0;
    clr_flags_i = '0;
    dato_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pndng", 64'(pndng_o), 64'h0);
    checkOutput("rst_full", 64'(full_o), 64'h0);
    checkOutput("rst_dato", 64'(dato_o), 64'h0);
    checkOutput("rst_count", 64'(count_o), 64'h0);
    checkOutput("rst_flags", 64'({overflow_o, underflow_o}), 64'h0);
    rst_n = 1'b1;

    $display("[TB] basic push/pop on ch0");
    applyStimulus(4'b0001, 4'b0000, 4'b0000, onChannel(0, 16'h0006));
    checkOutput("ch0_head_6", 64'(headOf(0)), 64'h6);
    checkOutput("ch0_count_1", 64'(countOf(0)), 64'd1);
    checkOutput("ch0_pndng", 64'(pndng_o), 64'b0001);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, onChannel(0, 16'h000A));
    checkOutput("ch0_head_still_6", 64'(headOf(0)), 64'h6);
    checkOutput("ch0_count_2", 64'(countOf(0)), 64'd2);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, '0);
    checkOutput("ch0_head_A", 64'(headOf(0)), 64'hA);
    checkOutput("ch0_count_pop1", 64'(countOf(0)), 64'd1);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, '0);
    checkOutput("ch0_head_0", 64'(headOf(0)), 64'h0);
    checkOutput("ch0_pndng_fall", 64'(pndng_o), 64'b0000);
    checkOutput("others_idle", 64'(dato_o), 64'h0);
    checkOutput("ch0_no_udf", 64'(underflow_o), 64'h0);

    $display("[TB] overflow on ch1");
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(4'b0010, 4'b0000, 4'b0000, onChannel(1, 16'(i)));
      if (i == 8) begin
        checkOutput("ch1_full_at8", 64'(full_o), 64'b0010);
        checkOutput("ch1_ovf_at8", 64'(overflow_o), 64'b0000);
      end
    end
    checkOutput("ch1_ovf_at9", 64'(overflow_o), 64'b0010);
    checkOutput("ch1_count_8", 64'(countOf(1)), 64'd8);
`ifdef FIFO_OVERWRITE_EN
    firstHead = 16'h2;
`else
    firstHead = 16'h1;
`endif
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("ch1_drain_%0d", i), 64'(headOf(1)), 64'(firstHead + 16'(i)));
      applyStimulus(4'b0000, 4'b0010, 4'b0000, '0);
    end
    checkOutput("ch1_empty", 64'(countOf(1)), 64'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0010, '0);
    checkOutput("ch1_ovf_clr", 64'(overflow_o), 64'b0000);

    $display("[TB] underflow on ch2");
    applyStimulus(4'b0000, 4'b0100, 4'b0000, '0);
    checkOutput("ch2_udf_set", 64'(underflow_o), 64'b0100);
    checkOutput("ch2_count_0", 64'(countOf(2)), 64'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0100, '0);
    checkOutput("ch2_udf_clr", 64'(underflow_o), 64'b0000);
    applyStimulus(4'b0000, 4'b0100, 4'b0100, '0);
    checkOutput("ch2_set_wins", 64'(underflow_o), 64'b0100);
    applyStimulus(4'b0000, 4'b0000, 4'b0100, '0);
    applyStimulus(4'b0100, 4'b0100, 4'b0000, onChannel(2, 16'h0033));
    checkOutput("ch2_pushpop_empty_head", 64'(headOf(2)), 64'h33);
    checkOutput("ch2_pushpop_empty_count", 64'(countOf(2)), 64'd1);
    checkOutput("ch2_pushpop_empty_udf", 64'(underflow_o), 64'b0100);
    applyStimulus(4'b0000, 4'b0100, 4'b0100, '0);
    checkOutput("ch2_drained", 64'(countOf(2)), 64'd0);

    $display("[TB] push+pop while full on ch3");
    for (int i = 0; i < 8; i++)
      applyStimulus(4'b1000, 4'b0000, 4'b0000, onChannel(3, 16'(16'h30 + i)));
    checkOutput("ch3_full", 64'(full_o), 64'b1000);
    applyStimulus(4'b1000, 4'b1000, 4'b0000, onChannel(3, 16'h000B));
    checkOutput("ch3_count_stays", 64'(countOf(3)), 64'd8);
    checkOutput("ch3_no_ovf", 64'(overflow_o), 64'b0000);
    for (int i = 1; i < 8; i++) begin
      checkOutput($sformatf("ch3_read_%0d", i), 64'(headOf(3)), 64'(16'h30 + i));
      applyStimulus(4'b0000, 4'b1000, 4'b0000, '0);
    end
    checkOutput("ch3_eighth_B", 64'(headOf(3)), 64'hB);
    applyStimulus(4'b0000, 4'b1000, 4'b0000, '0);
    checkOutput("ch3_empty", 64'(pndng_o), 64'b0000);

    $display("[TB] streaming with wrap and mid-stream reset on ch0");
    applyStimulus(4'b0001, 4'b0000, 4'b0000, onChannel(0, 16'h0040));
    applyStimulus(4'b0001, 4'b0000, 4'b0000, onChannel(0, 16'h0041));
    for (int i = 2; i < 22; i++) begin
      if (i == 16) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dato", 64'(dato_o), 64'h0);
        checkOutput("midrst_pndng", 64'(pndng_o), 64'h0);
        checkOutput("midrst_count", 64'(count_o), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        break;
      end
      applyStimulus(4'b0001, 4'b0001, 4'b0000, onChannel(0, 16'(16'h40 + i)));
      checkOutput($sformatf("stream_head_%0d", i), 64'(headOf(0)), 64'(16'h40 + i - 1));
      checkOutput($sformatf("stream_count_%0d", i), 64'(countOf(0)), 64'd2);
    end
    applyStimulus(4'b0001, 4'b0000, 4'b0000, onChannel(0, 16'h0005));
    applyStimulus(4'b0001, 4'b0000, 4'b0000, onChannel(0, 16'h0007));
    checkOutput("postrst_head_5", 64'(headOf(0)), 64'h5);
    checkOutput("postrst_count", 64'(countOf(0)), 64'd2);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, '0);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, '0);

    $display("[TB] all channels at once");
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 64'hC3C3_C2C2_C1C1_C0C0);
    checkOutput("all_ch0", 64'(headOf(0)), 64'hC0C0);
    checkOutput("all_ch1", 64'(headOf(1)), 64'hC1C1);
    checkOutput("all_ch2", 64'(headOf(2)), 64'hC2C2);
    checkOutput("all_ch3", 64'(headOf(3)), 64'hC3C3);
    checkOutput("all_counts", 64'(count_o), 64'h1111);
    applyStimulus(4'b0000, 4'b1111, 4'b0000, '0);
    checkOutput("all_empty", 64'(pndng_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
